scholar_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction port (fetch) and data port (mem stage).
- Sits between `scholar_riscv_core` and the memory/interconnect.
- Data requests normally win; a starvation counter guarantees fetch progress.
- Multi-cycle memories are supported: a request is held until `m_hit_i`. A transaction the requester abandons, e.g. fetch flushed by a branch, is drained safely.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/scholar_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_scholar_mem_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states and the
// latched memory request, sized for the widest supported configuration.
package arb_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   localparam int ARB_AW = 64;
   localparam int ARB_DW = 64;
   localparam int ARB_MW = ARB_DW / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DRAIN   = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic [ARB_AW-1:0] addr;
      logic              rden;
      logic              wren;
      logic [ARB_DW-1:0] wdata;
      logic [ARB_MW-1:0] wmask;
   } mem_req_t;

endpackage

// File: rtl/scholar_mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core.
// Data wins by default; a starvation counter forces periodic fetch grants.
module scholar_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int StarveLimit = 4
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [ADDR_WIDTH-1:0]   i_m_addr_i,
   input  logic                    i_m_rden_i,
   output logic [31:0]             i_m_rdata_o,
   output logic                    i_m_hit_o,
   input  logic [ADDR_WIDTH-1:0]   d_m_addr_i,
   input  logic                    d_m_rden_i,
   input  logic                    d_m_wren_i,
   input  logic [DATA_WIDTH-1:0]   d_m_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] d_m_wmask_i,
   output logic [DATA_WIDTH-1:0]   d_m_rdata_o,
   output logic                    d_m_hit_o,
   output logic [ADDR_WIDTH-1:0]   m_addr_o,
   output logic                    m_rden_o,
   output logic                    m_wren_o,
   output logic [DATA_WIDTH-1:0]   m_wdata_o,
   output logic [DATA_WIDTH/8-1:0] m_wmask_o,
   input  logic [DATA_WIDTH-1:0]   m_rdata_i,
   input  logic                    m_hit_i
);

   localparam int MW = DATA_WIDTH / 8;
   localparam logic [3:0] LIMIT = 4'(StarveLimit);

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
      $fatal(1, "scholar_mem_arbiter: DATA_WIDTH must be 32 or 64");
   end
   if (StarveLimit < 1 || StarveLimit > 15) begin : g_bad_limit
      $fatal(1, "scholar_mem_arbiter: StarveLimit must be 1..15");
   end

   arb_state_t state, state_nx;
   mem_req_t   lat, lat_nx, req_d, req_i;
   logic [3:0] starve_cnt, starve_nx;
   logic       d_req, grant_d, grant_i, rearb, hit_i, hit_d;

   assign d_req   = d_m_rden_i | d_m_wren_i;
   assign grant_d = d_req && (!i_m_rden_i || starve_cnt < LIMIT);
   assign grant_i = !grant_d && i_m_rden_i;

   // A store beats a load when both are raised on the data port.
   always_comb begin
      req_d       = '0;
      req_d.addr  = ARB_AW'(d_m_addr_i);
      req_d.wren  = d_m_wren_i;
      req_d.rden  = d_m_rden_i & ~d_m_wren_i;
      req_d.wdata = ARB_DW'(d_m_wdata_i);
      req_d.wmask = ARB_MW'(d_m_wmask_i);
      req_i       = '0;
      req_i.addr  = ARB_AW'(i_m_addr_i);
      req_i.rden  = 1'b1;
   end

   always_comb begin
      state_nx  = state;
      lat_nx    = lat;
      starve_nx = starve_cnt;
      rearb     = 1'b0;
      hit_i     = 1'b0;
      hit_d     = 1'b0;
      case (state)
         IDLE: rearb = 1'b1;
         SERVE_I: begin
            if (m_hit_i) begin
               hit_i = i_m_rden_i;
               rearb = 1'b1;
            end else if (!i_m_rden_i) begin
               state_nx = DRAIN;
            end
         end
         SERVE_D: begin
            if (m_hit_i) begin
               hit_d = d_req;
               rearb = 1'b1;
            end else if (!d_req) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: rearb = m_hit_i;
         default: state_nx = IDLE;
      endcase
      // Re-arbitrating in the hit cycle gives back-to-back grants.
      if (rearb) begin
         if (grant_d) begin
            state_nx = SERVE_D;
            lat_nx   = req_d;
            if (i_m_rden_i && starve_cnt < LIMIT) starve_nx = starve_cnt + 4'd1;
         end else if (grant_i) begin
            state_nx  = SERVE_I;
            lat_nx    = req_i;
            starve_nx = '0;
         end else begin
            state_nx = IDLE;
         end
      end
      if (state == IDLE && !i_m_rden_i) starve_nx = '0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         lat        <= '0;
         starve_cnt <= '0;
      end else begin
         state      <= state_nx;
         lat        <= lat_nx;
         starve_cnt <= starve_nx;
      end
   end

   logic active;
   assign active    = (state != IDLE);
   assign m_addr_o  = active ? lat.addr[ADDR_WIDTH-1:0] : '0;
   assign m_rden_o  = active & lat.rden;
   assign m_wren_o  = active & lat.wren;
   assign m_wdata_o = active ? lat.wdata[DATA_WIDTH-1:0] : '0;
   assign m_wmask_o = active ? lat.wmask[MW-1:0] : '0;

   assign i_m_hit_o   = hit_i;
   assign d_m_hit_o   = hit_d;
   assign d_m_rdata_o = rstn_i ? m_rdata_i : '0;

   if (DATA_WIDTH == 64) begin : g_rd64
      assign i_m_rdata_o = !rstn_i ? '0 : lat.addr[2] ? m_rdata_i[63:32] : m_rdata_i[31:0];
   end else begin : g_rd32
      assign i_m_rdata_o = rstn_i ? m_rdata_i[31:0] : '0;
   end

   // Upper bits of the wide latch are unused in narrow configurations.
   logic unused_lat;
   assign unused_lat = ^lat;

endmodule

// File: tb/tb_scholar_mem_arbiter.sv
// Directed bench for scholar_mem_arbiter (64-bit data, StarveLimit 4): fetch,
// store/fetch collision, starvation rotation, drain and async reset.
module tb_scholar_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic [31:0] i_m_addr_i;
   logic        i_m_rden_i;
   logic [31:0] i_m_rdata_o;
   logic        i_m_hit_o;
   logic [31:0] d_m_addr_i;
   logic        d_m_rden_i, d_m_wren_i;
   logic [63:0] d_m_wdata_i;
   logic [7:0]  d_m_wmask_i;
   logic [63:0] d_m_rdata_o;
   logic        d_m_hit_o;
   logic [31:0] m_addr_o;
   logic        m_rden_o, m_wren_o;
   logic [63:0] m_wdata_o;
   logic [7:0]  m_wmask_o;
   logic [63:0] m_rdata_i;
   logic        m_hit_i;

   int n_cmp = 0;
   int n_bad = 0;

   scholar_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .StarveLimit(4)) dut (
      .clk_i(clk), .rstn_i(rstn_i),
      .i_m_addr_i(i_m_addr_i), .i_m_rden_i(i_m_rden_i),
      .i_m_rdata_o(i_m_rdata_o), .i_m_hit_o(i_m_hit_o),
      .d_m_addr_i(d_m_addr_i), .d_m_rden_i(d_m_rden_i), .d_m_wren_i(d_m_wren_i),
      .d_m_wdata_i(d_m_wdata_i), .d_m_wmask_i(d_m_wmask_i),
      .d_m_rdata_o(d_m_rdata_o), .d_m_hit_o(d_m_hit_o),
      .m_addr_o(m_addr_o), .m_rden_o(m_rden_o), .m_wren_o(m_wren_o),
      .m_wdata_o(m_wdata_o), .m_wmask_o(m_wmask_o),
      .m_rdata_i(m_rdata_i), .m_hit_i(m_hit_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      i_m_addr_i = '0; i_m_rden_i = 1'b0;
      d_m_addr_i = '0; d_m_rden_i = 1'b0; d_m_wren_i = 1'b0;
      d_m_wdata_i = '0; d_m_wmask_i = '0;
      m_rdata_i = '0; m_hit_i = 1'b0;
   endtask

   initial begin
      // Reset with busy-looking inputs: every output must be 0.
      clear_inputs();
      rstn_i = 1'b0;
      i_m_rden_i = 1'b1; d_m_wren_i = 1'b1; m_hit_i = 1'b1;
      m_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      #3;
      chk("rst_m_rden", m_rden_o, 0);
      chk("rst_m_wren", m_wren_o, 0);
      chk("rst_m_addr", m_addr_o, 0);
      chk("rst_i_hit", i_m_hit_o, 0);
      chk("rst_d_hit", d_m_hit_o, 0);
      chk("rst_d_rdata", d_m_rdata_o, 0);
      chk("rst_i_rdata", i_m_rdata_o, 0);
      #9;
      clear_inputs();
      rstn_i = 1'b1;
      nxt();

      // Single fetch, hit on the third serve cycle.
      i_m_rden_i = 1'b1; i_m_addr_i = 32'h10;
      settle(); chk("t1_idle_rden", m_rden_o, 0);
      nxt(); settle();
      chk("t1_rden", m_rden_o, 1);
      chk("t1_addr", m_addr_o, 32'h10);
      chk("t1_wren", m_wren_o, 0);
      chk("t1_early_hit", i_m_hit_o, 0);
      nxt();
      nxt();
      m_hit_i = 1'b1; m_rdata_i = 64'hCAFEF00D_00500093; i_m_addr_i = 32'h14;
      settle();
      chk("t1_i_hit", i_m_hit_o, 1);
      chk("t1_i_rdata", i_m_rdata_o, 32'h00500093);
      chk("t1_d_hit", d_m_hit_o, 0);
      nxt(); m_hit_i = 1'b0; settle();
      chk("t1_b2b_addr", m_addr_o, 32'h14);
      chk("t1_b2b_nohit", i_m_hit_o, 0);

      // Upper half selected by addr[2] on a 64-bit memory.
      nxt(); m_hit_i = 1'b1; m_rdata_i = 64'h11111111_22222222; i_m_addr_i = 32'h18;
      settle();
      chk("t5_i_hit", i_m_hit_o, 1);
      chk("t5_i_rdata", i_m_rdata_o, 32'h11111111);
      chk("t5_d_rdata", d_m_rdata_o, 64'h11111111_22222222);

      // Fetch abandoned a cycle after grant: request held until the late hit.
      nxt(); m_hit_i = 1'b0; i_m_rden_i = 1'b0; settle();
      chk("t4_addr0", m_addr_o, 32'h18);
      chk("t4_rden0", m_rden_o, 1);
      nxt(); i_m_addr_i = 32'h999;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t4_drain_addr", m_addr_o, 32'h18);
         chk("t4_drain_rden", m_rden_o, 1);
         chk("t4_drain_hit", i_m_hit_o, 0);
         nxt();
      end
      m_hit_i = 1'b1; d_m_rden_i = 1'b1; d_m_addr_i = 32'h200;
      settle();
      chk("t4_hit_i_discard", i_m_hit_o, 0);
      chk("t4_hit_d", d_m_hit_o, 0);
      nxt(); m_hit_i = 1'b0; settle();
      chk("t4_next_addr", m_addr_o, 32'h200);
      chk("t4_next_rden", m_rden_o, 1);

      // Load dropped in its hit cycle: response discarded, back to idle.
      nxt(); m_hit_i = 1'b1; d_m_rden_i = 1'b0; settle();
      chk("discard_d_hit", d_m_hit_o, 0);
      nxt(); settle();
      chk("idle_hit_i", i_m_hit_o, 0);
      chk("idle_hit_d", d_m_hit_o, 0);
      chk("idle_rden", m_rden_o, 0);

      // Fetch and store (with load also raised) in the same cycle.
      nxt(); m_hit_i = 1'b0;
      i_m_rden_i = 1'b1; i_m_addr_i = 32'h20;
      d_m_wren_i = 1'b1; d_m_rden_i = 1'b1; d_m_addr_i = 32'h100;
      d_m_wdata_i = 64'hDEADBEEF; d_m_wmask_i = 8'h0F;
      settle(); chk("t2_idle_wren", m_wren_o, 0);
      nxt(); settle();
      chk("t2_wren", m_wren_o, 1);
      chk("t2_rden_fwd", m_rden_o, 0);
      chk("t2_addr", m_addr_o, 32'h100);
      chk("t2_wdata", m_wdata_o, 64'hDEADBEEF);
      chk("t2_wmask", m_wmask_o, 8'h0F);
      nxt(); m_hit_i = 1'b1; settle();
      chk("t2_d_hit", d_m_hit_o, 1);
      chk("t2_i_hit", i_m_hit_o, 0);
      #1 d_m_wren_i = 1'b0; d_m_rden_i = 1'b0;
      nxt(); m_hit_i = 1'b0; settle();
      chk("t2_fetch_addr", m_addr_o, 32'h20);
      chk("t2_fetch_rden", m_rden_o, 1);
      chk("t2_fetch_wren", m_wren_o, 0);
      nxt(); m_hit_i = 1'b1; settle();
      chk("t2_fetch_hit", i_m_hit_o, 1);
      #1 i_m_rden_i = 1'b0;
      nxt(); m_hit_i = 1'b0; settle();
      chk("t2_idle", m_rden_o, 0);

      // Starvation: single-cycle memory, both ports always requesting.
      nxt();
      i_m_rden_i = 1'b1; i_m_addr_i = 32'h40;
      d_m_rden_i = 1'b1; d_m_addr_i = 32'h300;
      m_hit_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         nxt(); settle();
         chk("t3_addr", m_addr_o, (k % 5 != 4) ? 32'h300 : 32'h40);
         chk("t3_d_hit", d_m_hit_o, (k % 5 != 4) ? 1 : 0);
         chk("t3_i_hit", i_m_hit_o, (k % 5 != 4) ? 0 : 1);
      end

      // Asynchronous reset in the middle of a data transaction.
      nxt(); m_hit_i = 1'b0; i_m_rden_i = 1'b0; m_rdata_i = 64'h5555_5555_5555_5555;
      settle();
      chk("t6_pre_rden", m_rden_o, 1);
      chk("t6_pre_addr", m_addr_o, 32'h300);
      #1 rstn_i = 1'b0; m_hit_i = 1'b1;
      #1;
      chk("t6_rst_rden", m_rden_o, 0);
      chk("t6_rst_addr", m_addr_o, 0);
      chk("t6_rst_d_hit", d_m_hit_o, 0);
      chk("t6_rst_i_hit", i_m_hit_o, 0);
      chk("t6_rst_d_rdata", d_m_rdata_o, 0);
      #2 clear_inputs(); rstn_i = 1'b1;
      nxt(); settle();
      chk("t6_post_rden", m_rden_o, 0);
      chk("t6_post_addr", m_addr_o, 0);
      d_m_wren_i = 1'b1; d_m_addr_i = 32'h500;
      d_m_wdata_i = 64'h12345678_9ABCDEF0; d_m_wmask_i = 8'hF0;
      nxt(); settle();
      chk("t6_st_wren", m_wren_o, 1);
      chk("t6_st_addr", m_addr_o, 32'h500);
      chk("t6_st_wdata", m_wdata_o, 64'h12345678_9ABCDEF0);
      chk("t6_st_wmask", m_wmask_o, 8'hF0);
      nxt(); m_hit_i = 1'b1; settle();
      chk("t6_st_hit", d_m_hit_o, 1);
      #1 d_m_wren_i = 1'b0;
      nxt(); m_hit_i = 1'b0; settle();
      chk("t6_end_wren", m_wren_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
